// File: rtl/mod_inv_pw.sv
// Binary extended-Euclid modular inverse / division engine: r = b * a^-1 mod p
// for odd p, one job at a time behind valid/ready handshakes.
module mod_inv_pw #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r,
    output logic         err,
    output logic         busy
);

    localparam int           CW       = $clog2(4 * W) + 1;
    localparam logic [CW-1:0] WD_LIMIT = CW'(4 * W);
    localparam logic [W-1:0]  ONE      = W'(1);
    localparam logic [W-1:0]  THREE    = W'(3);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  u_q, u_d;
    logic [W-1:0]  v_q, v_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  p_q, p_d;
    logic [W-1:0]  r_q, r_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bad_job;

    // Halve val modulo odd m; for odd val, (val+m)/2 == (val>>1)+(m>>1)+1.
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] val, input logic [W-1:0] m);
        if (val[0])
            return (val >> 1) + (m >> 1) + ONE;
        return val >> 1;
    endfunction

    // (s - t) mod m for s, t < m; when s < t, m - (t - s) stays within W bits.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] s, input logic [W-1:0] t,
                                             input logic [W-1:0] m);
        if (s >= t)
            return s - t;
        return m - (t - s);
    endfunction

    assign bad_job = !p[0] || (p < THREE) || (a == '0) || (a >= p) || (b >= p);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            r_q     <= r_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        r_d     = r_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    p_d   = p;
                    u_d   = a;
                    v_d   = p;
                    x_d   = b;
                    y_d   = '0;
                    cnt_d = '0;
                    r_d   = '0;
                    err_d = bad_job;
                    state_d = bad_job ? DONE : RUN;
                end
            end
            RUN: begin
                if (u_q == ONE) begin
                    r_d     = x_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (v_q == ONE) begin
                    r_d     = y_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((u_q == '0) || (v_q == '0) || (cnt_q >= WD_LIMIT)) begin
                    // Common factor with p, or the step budget ran out.
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!u_q[0]) begin
                        u_d = u_q >> 1;
                        x_d = half_mod(x_q, p_q);
                    end
                    if (!v_q[0]) begin
                        v_d = v_q >> 1;
                        y_d = half_mod(y_q, p_q);
                    end
                    if (u_q[0] && v_q[0]) begin
                        if (u_q >= v_q) begin
                            u_d = u_q - v_q;
                            x_d = sub_mod(x_q, y_q, p_q);
                        end else begin
                            v_d = v_q - u_q;
                            y_d = sub_mod(y_q, x_q, p_q);
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign r         = r_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mod_inv_pw.sv
// Directed and reference-model checks of mod_inv_pw at W=4 and W=8.
module tb_mod_inv_pw;

    logic       clk;
    logic       rst;
    logic       iv4, ir4, ov4, or4, e4, busy4;
    logic [3:0] a4, b4, p4, r4;
    logic       iv8, ir8, ov8, or8, e8, busy8;
    logic [7:0] a8, b8, p8, r8;

    int n_checks;
    int n_fail;

    mod_inv_pw #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .p(p4),
        .out_valid(ov4), .out_ready(or4), .r(r4), .err(e4), .busy(busy4)
    );

    mod_inv_pw #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .p(p8),
        .out_valid(ov8), .out_ready(or8), .r(r8), .err(e8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input int av, input int bv, input int pv);
        if (w == 4) begin
            iv4 = v; a4 = 4'(av); b4 = 4'(bv); p4 = 4'(pv);
        end else begin
            iv8 = v; a8 = 8'(av); b8 = 8'(bv); p8 = 8'(pv);
        end
    endtask

    task automatic start_job(input int w, input int av, input int bv, input int pv);
        @(negedge clk);
        drive(w, 1'b1, av, bv, pv);
        @(posedge clk);
        #1;
        if (w == 4) iv4 = 1'b0;
        else        iv8 = 1'b0;
    endtask

    // Returns at the first negedge with out_valid high; lat counts edges since accept.
    task automatic wait_done(input int w, output int rr, output int ee, output int lat);
        logic ov;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 200) begin
            @(negedge clk);
            lat++;
            ov = (w == 4) ? ov4 : ov8;
        end
        if (!ov) check("out_valid_timeout", int'(ov), 1);
        rr = (w == 4) ? int'(r4) : int'(r8);
        ee = (w == 4) ? int'(e4) : int'(e8);
    endtask

    task automatic run_job(input int w, input int av, input int bv, input int pv,
                           output int rr, output int ee, output int lat);
        start_job(w, av, bv, pv);
        wait_done(w, rr, ee, lat);
        $display("job w=%0d p=%0d a=%0d b=%0d -> r=%0d err=%0d lat=%0d", w, pv, av, bv, rr, ee, lat);
    endtask

    function automatic int gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    int rr, ee, lat, k, pv, av, bv, exp_r, exp_e, seen;
    int inv7[6] = '{1, 4, 5, 2, 3, 6};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        or4 = 1'b1; or8 = 1'b1;
        drive(4, 1'b0, 0, 0, 0);
        drive(8, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(ir8), 1);
        check("rst_out_valid", int'(ov8), 0);
        check("rst_busy", int'(busy8), 0);
        check("rst_r", int'(r8), 0);
        check("rst_err", int'(e8), 0);
        check("rst_in_ready4", int'(ir4), 1);

        run_job(4, 5, 1, 13, rr, ee, lat);
        check("inv13_5_r", rr, 8);
        check("inv13_5_err", ee, 0);
        check("inv13_5_lat_le15", int'(lat <= 15), 1);

        for (int i = 1; i <= 6; i++) begin
            run_job(4, i, 1, 7, rr, ee, lat);
            check($sformatf("inv7_%0d", i), rr, inv7[i-1]);
            check($sformatf("inv7_%0d_err", i), ee, 0);
        end

        run_job(4, 3, 5, 11, rr, ee, lat);
        check("div11_5_3_r", rr, 9);
        check("div11_5_3_err", ee, 0);
        run_job(4, 1, 7, 11, rr, ee, lat);
        check("div11_7_1_r", rr, 7);
        check("div11_7_1_lat", lat, 2);

        run_job(8, 2, 1, 251, rr, ee, lat);
        check("inv251_2_r", rr, 126);
        check("inv251_2_err", ee, 0);

        run_job(4, 6, 1, 15, rr, ee, lat);
        check("gcd15_6_err", ee, 1);
        check("gcd15_6_r", rr, 0);
        check("gcd15_6_via_run", int'(lat >= 2), 1);
        run_job(4, 5, 1, 12, rr, ee, lat);
        check("even_p_err", ee, 1);
        check("even_p_lat", lat, 1);
        run_job(4, 0, 1, 13, rr, ee, lat);
        check("a_zero_err", ee, 1);
        check("a_zero_r", rr, 0);
        run_job(4, 13, 1, 13, rr, ee, lat);
        check("a_eq_p_err", ee, 1);
        run_job(4, 3, 13, 13, rr, ee, lat);
        check("b_eq_p_err", ee, 1);

        // Backpressure: 3 * 84 = 252 = 1 mod 251.
        or8 = 1'b0;
        run_job(8, 3, 1, 251, rr, ee, lat);
        check("bp_r", rr, 84);
        for (int i = 0; i < 5; i++) begin
            iv8 = (i % 2 == 0); a8 = 8'd5; b8 = 8'd1; p8 = 8'd251;
            @(negedge clk);
            check($sformatf("bp_hold_ov_%0d", i), int'(ov8), 1);
            check($sformatf("bp_hold_r_%0d", i), int'(r8), 84);
            check($sformatf("bp_hold_err_%0d", i), int'(e8), 0);
            check($sformatf("bp_hold_ready_%0d", i), int'(ir8), 0);
        end
        iv8 = 1'b1; a8 = 8'd2; b8 = 8'd1; p8 = 8'd251;
        or8 = 1'b1;
        @(negedge clk);
        check("b2b_idle_ready", int'(ir8), 1);
        check("b2b_idle_ov", int'(ov8), 0);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        check("b2b_accepted_busy", int'(busy8), 1);
        wait_done(8, rr, ee, lat);
        $display("job w=8 p=251 a=2 b=1 -> r=%0d err=%0d lat=%0d (back-to-back)", rr, ee, lat);
        check("b2b_r", rr, 126);

        // Reset in the middle of a running job.
        start_job(8, 200, 1, 251);
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy", int'(busy8), 1);
        check("midrun_ov", int'(ov8), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy8), 0);
        check("midrst_ready", int'(ir8), 1);
        check("midrst_ov", int'(ov8), 0);
        check("midrst_r", int'(r8), 0);
        check("midrst_err", int'(e8), 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        check("midrst_no_output", seen, 0);
        run_job(8, 2, 1, 251, rr, ee, lat);
        check("post_rst_r", rr, 126);

        for (int n = 0; n < 1000; n++) begin
            pv = $urandom_range(3, 255) | 1;
            av = $urandom_range(1, pv - 1);
            bv = $urandom_range(0, pv - 1);
            exp_e = (gcd(pv, av) > 1) ? 1 : 0;
            exp_r = 0;
            if (!exp_e) begin
                for (int c = 0; c < pv; c++)
                    if ((c * av) % pv == bv) exp_r = c;
            end
            run_job(8, av, bv, pv, rr, ee, lat);
            k = lat - 2;
            check($sformatf("sweep%0d_err", n), ee, exp_e);
            check($sformatf("sweep%0d_r", n), rr, exp_r);
            check($sformatf("sweep%0d_steps_le31", n), int'(k <= 31), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
